// File: rtl/adc_channel_scheduler.sv
// Round-robin scheduler sharing one ADC serial driver among N_CH level requesters.
// Define ADC_SCHED_PRIORITY_EN to give channel 0 precedence on every other conversion.
module adc_channel_scheduler #(
    parameter int N_CH           = 3,
    parameter int DATA_W         = 12,
    parameter int GAP_CYCLES     = 2500,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    input  logic [N_CH-1:0]          req,
    output logic                     adc_start,
    output logic [CW-1:0]            adc_chan,
    input  logic                     adc_done,
    input  logic [DATA_W-1:0]        adc_data,
    output logic [N_CH-1:0]          grant,
    output logic [N_CH-1:0]          res_valid,
    output logic [N_CH*DATA_W-1:0]   results,
    input  logic                     err_clr,
    output logic                     timeout_err
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef ADC_SCHED_PRIORITY_EN
    localparam logic SKIP0 = 1'b1;
`else
    localparam logic SKIP0 = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CW-1:0]    last;
    logic [CW:0]      rr_sel;
    logic             pick_vld;
    logic             pick_upd_last;
    logic [CW-1:0]    pick;
    logic             conv_done;
    logic             conv_timeout;

    // Returns {found, channel}: first requester after 'from', wrapping, 'from' itself last.
    function automatic logic [CW:0] rr_search(input logic [N_CH-1:0] r,
                                              input logic [CW-1:0]   from,
                                              input logic            skip0);
        logic [CW:0] found;
        logic [CW:0] idx;
        found = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = {1'b0, from} + (CW+1)'(i);
            if (idx >= (CW+1)'(N_CH))
                idx = idx - (CW+1)'(N_CH);
            if (r[idx[CW-1:0]] && !(skip0 && idx == '0))
                found = {1'b1, idx[CW-1:0]};
        end
        return found;
    endfunction

    assign rr_sel       = rr_search(req, last, SKIP0);
    assign conv_done    = (state == S_WAIT) && adc_done;
    assign conv_timeout = (state == S_WAIT) && !adc_done && (cnt == TO_LAST);

`ifdef ADC_SCHED_PRIORITY_EN
    // Channel 0 wins unless it was served last; it never moves the round-robin pointer.
    logic prev_ch0;

    always_comb begin
        pick_vld      = 1'b0;
        pick          = '0;
        pick_upd_last = 1'b0;
        if (req[0] && !prev_ch0) begin
            pick_vld = 1'b1;
        end else if (rr_sel[CW]) begin
            pick_vld      = 1'b1;
            pick          = rr_sel[CW-1:0];
            pick_upd_last = 1'b1;
        end else if (req[0]) begin
            pick_vld = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            prev_ch0 <= 1'b0;
        else if (state == S_IDLE && pick_vld)
            prev_ch0 <= (pick == '0);
    end
`else
    always_comb begin
        pick_vld      = rr_sel[CW];
        pick          = rr_sel[CW-1:0];
        pick_upd_last = rr_sel[CW];
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (conv_done || conv_timeout) state_nxt = S_GAP;
            S_GAP:   if (cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        adc_start = (state == S_START);
        grant     = '0;
        for (int k = 0; k < N_CH; k++)
            grant[k] = (state == S_START || state == S_WAIT) && (adc_chan == CW'(k));
    end

    // One counter serves both the WAIT timeout and the GAP length; it restarts on entry to each.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt         <= '0;
            adc_chan    <= '0;
            last        <= CW'(N_CH - 1);
            res_valid   <= '0;
            results     <= '0;
            timeout_err <= 1'b0;
        end else begin
            res_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        adc_chan <= pick;
                        if (pick_upd_last)
                            last <= pick;
                    end
                end
                S_START: cnt <= '0;
                S_WAIT:  cnt <= (conv_done || conv_timeout) ? '0 : cnt + CNT_W'(1);
                S_GAP:   cnt <= cnt + CNT_W'(1);
                default: cnt <= '0;
            endcase
            if (conv_done) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (adc_chan == CW'(k)) begin
                        results[k*DATA_W +: DATA_W] <= adc_data;
                        res_valid[k]                <= 1'b1;
                    end
                end
            end
            if (conv_timeout)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

endmodule
